csi2_pkt_parser: RTL

Consumes the 32-bit word stream produced by the lane-to-word mapper (first received byte in bits [7:0]) and decodes one CSI-2 packet per HS transmission. It checks the packet-header ECC and reports short-packet sync events (frame/line start/end). For long packets it strips the header, emits the payload as 32-bit words with byte enables, and extracts the 16-bit packet CRC. It sits between the word mapper and the pixel unpacker/CRC checker.

---
 rtl/csi2_pkt_parser.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/csi2_pkt_parser.sv
// CSI-2 packet parser: header ECC check, sync pulses, payload words with byte enables, CRC extraction.
// Latency 1 cycle, all outputs registered; no backpressure, one word accepted per cycle.
module csi2_pkt_parser #(
  parameter bit ECC_CHECK = 1'b1
) (
  input  logic        byte_clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic        eot_i,
  output logic [31:0] pkt_data_o,
  output logic        pkt_valid_o,
  output logic [3:0]  pkt_be_o,
  output logic        pkt_last_o,
  output logic [1:0]  vc_o,
  output logic [5:0]  dt_o,
  output logic [15:0] wc_o,
  output logic        fs_o,
  output logic        fe_o,
  output logic        ls_o,
  output logic        le_o,
  output logic [15:0] crc_o,
  output logic        crc_valid_o,
  output logic        hdr_err_o,
  output logic        trunc_err_o
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, SKIP} state_t;

  state_t      state;
  logic [15:0] bytes_left;
  logic [7:0]  crc_lo;
  logic        crc_two;
  logic [7:0]  ecc_exp;
  logic        ecc_bad;
  logic        crc_done_now;

  // Each parity bit covers the header bits set in its mask.
  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  assign ecc_exp = {2'b00, calc_ecc(data_i[23:0])};
  assign ecc_bad = (ecc_exp != data_i[31:24]);

  // CRC finishes this cycle in the CRC state, or when the last payload word also carries both CRC bytes.
  assign crc_done_now = valid_i &&
                        ((state == CRC) ||
                         (state == PAYLOAD && (bytes_left == 16'd1 || bytes_left == 16'd2)));

  always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      bytes_left  <= '0;
      crc_lo      <= '0;
      crc_two     <= 1'b0;
      pkt_data_o  <= '0;
      pkt_valid_o <= 1'b0;
      pkt_be_o    <= '0;
      pkt_last_o  <= 1'b0;
      vc_o        <= '0;
      dt_o        <= '0;
      wc_o        <= '0;
      fs_o        <= 1'b0;
      fe_o        <= 1'b0;
      ls_o        <= 1'b0;
      le_o        <= 1'b0;
      crc_o       <= '0;
      crc_valid_o <= 1'b0;
      hdr_err_o   <= 1'b0;
      trunc_err_o <= 1'b0;
    end else begin
      pkt_valid_o <= 1'b0;
      pkt_last_o  <= 1'b0;
      fs_o        <= 1'b0;
      fe_o        <= 1'b0;
      ls_o        <= 1'b0;
      le_o        <= 1'b0;
      crc_valid_o <= 1'b0;
      hdr_err_o   <= 1'b0;
      trunc_err_o <= 1'b0;

      case (state)
        IDLE: begin
          if (valid_i) begin
            vc_o <= data_i[7:6];
            dt_o <= data_i[5:0];
            wc_o <= data_i[23:8];
            if (ECC_CHECK && ecc_bad) begin
              hdr_err_o <= 1'b1;
              state     <= SKIP;
            end else if (data_i[5:4] == 2'b00) begin
              fs_o  <= (data_i[5:0] == 6'h00);
              fe_o  <= (data_i[5:0] == 6'h01);
              ls_o  <= (data_i[5:0] == 6'h02);
              le_o  <= (data_i[5:0] == 6'h03);
              state <= SKIP;
            end else if (data_i[23:8] != 16'd0) begin
              bytes_left <= data_i[23:8];
              state      <= PAYLOAD;
            end else begin
              crc_two <= 1'b1;
              state   <= CRC;
            end
          end
        end

        PAYLOAD: begin
          if (valid_i) begin
            pkt_valid_o <= 1'b1;
            pkt_data_o  <= data_i;
            if (bytes_left > 16'd4) begin
              pkt_be_o   <= 4'b1111;
              bytes_left <= bytes_left - 16'd4;
            end else begin
              pkt_last_o <= 1'b1;
              bytes_left <= '0;
              case (bytes_left[2:0])
                3'd1: begin
                  pkt_be_o    <= 4'b0001;
                  crc_o       <= data_i[23:8];
                  crc_valid_o <= 1'b1;
                  state       <= SKIP;
                end
                3'd2: begin
                  pkt_be_o    <= 4'b0011;
                  crc_o       <= data_i[31:16];
                  crc_valid_o <= 1'b1;
                  state       <= SKIP;
                end
                3'd3: begin
                  pkt_be_o <= 4'b0111;
                  crc_lo   <= data_i[31:24];
                  crc_two  <= 1'b0;
                  state    <= CRC;
                end
                default: begin
                  pkt_be_o <= 4'b1111;
                  crc_two  <= 1'b1;
                  state    <= CRC;
                end
              endcase
            end
          end
        end

        CRC: begin
          if (valid_i) begin
            crc_o       <= crc_two ? data_i[15:0] : {data_i[7:0], crc_lo};
            crc_valid_o <= 1'b1;
            state       <= SKIP;
          end
        end

        default: ;
      endcase

      if (eot_i) begin
        state       <= IDLE;
        trunc_err_o <= (state == PAYLOAD || state == CRC) && !crc_done_now;
      end
    end
  end

endmodule
